// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared package for the odd-even sorter chain
// Purpose : frame-width function, element-slice helper and the output FSM state enum.
// Ports   : none (package).
package sort_pkg;

  // Upper bounds for the generic slice helper. Callers zero-extend frames
  // to MAX_FRAME_W and truncate the result to their element width.
  localparam int unsigned MAX_FRAME_W = 1024;
  localparam int unsigned MAX_ELEM_W  = 64;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sort_state_e;

  function automatic int unsigned FRAME_W(input int unsigned n, input int unsigned k);
    return n * k;
  endfunction

  // Element idx occupies bits [(idx+1)*k-1 -: k]. An out-of-range idx
  // shifts everything out and yields zero.
  function automatic logic [MAX_ELEM_W-1:0] elem_slice(
    input logic [MAX_FRAME_W-1:0] frame,
    input int unsigned            idx,
    input int unsigned            k
  );
    logic [MAX_FRAME_W-1:0] shifted;
    logic [MAX_ELEM_W-1:0]  mask;
    shifted = frame >> (idx * k);
    mask    = {MAX_ELEM_W{1'b1}} >> (MAX_ELEM_W - k);
    return shifted[MAX_ELEM_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/sort_frame_fifo.sv
// rtl/sort_frame_fifo.sv - frame-wide synchronous FIFO for the sorter output stage
// Purpose : buffers whole DATA_W-bit frames; head is visible combinationally on pop_data_o.
// Ports   : clk_i, rst_i (async, active-high)
//           push_i/push_data_i  write a frame (ignored when full unless popping this cycle)
//           pop_i/pop_data_o    remove the head frame (ignored when empty)
//           count_o             frames held, 0..DEPTH
//           full_o, empty_o     occupancy flags
module sort_frame_fifo
  import sort_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle:
  // the write lands in the slot the read is vacating.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count_q says it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sort_out_serializer.sv
// rtl/sort_out_serializer.sv - frame capture, buffering and element-serial output of sorted vectors
// Purpose : accepts one n*k-bit sorted frame per cycle without back-pressure, buffers frames
//           in sort_frame_fifo and emits them one k-bit element per valid/ready beat,
//           element 0 first, out_last on element n-1. Frames arriving on a full FIFO are
//           dropped and counted in a saturating counter.
// Macro   : SORT_ORDER_CHECK_EN - when defined, builds an unsigned order checker that sets
//           the sticky order_err flag if an element is smaller than its predecessor.
// Ports   : clk, reset (async, active-high)
//           frame_valid, in_frame[n*k]   frame input, element i at [(i+1)*k-1 -: k]
//           out_valid, out_ready, out_data[k], out_last   element stream
//           drop_cnt[CNT_W]   frames dropped on full FIFO (saturating)
//           order_err         sticky order-violation flag
module sort_out_serializer
  import sort_pkg::*;
#(
  parameter int n          = 4,
  parameter int k          = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_valid,
  input  logic [n*k-1:0]   in_frame,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [k-1:0]     out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             order_err
);

  localparam int FW    = FRAME_W(n, k);
  localparam int IDX_W = $clog2(n);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(n - 1);

  sort_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_head;
  logic [CW-1:0]    fifo_count;
  logic             beat, frame_drop;

  sort_frame_fifo #(
    .DATA_W (FW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (fifo_push),
    .push_data_i (in_frame),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // The sorter cannot be stalled, so a frame is either taken now or lost.
  assign fifo_push  = frame_valid && ((fifo_count < CW'(FIFO_DEPTH)) || fifo_pop);
  assign frame_drop = frame_valid && fifo_full && !fifo_pop;

  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = k'(elem_slice(MAX_FRAME_W'(frame_q), 32'(idx_q), k));
  assign beat      = out_valid && out_ready;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    frame_d  = frame_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          frame_d  = fifo_head;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Reload on the last beat so consecutive frames leave no bubble.
            fifo_pop = 1'b1;
            frame_d  = fifo_head;
            idx_d    = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef SORT_ORDER_CHECK_EN
  logic         order_err_q, order_err_d;
  logic [k-1:0] prev_elem;

  // At idx_q==0 the slice index underflows and reads zero; the compare is gated off there.
  assign prev_elem = k'(elem_slice(MAX_FRAME_W'(frame_q), 32'(idx_q) - 32'd1, k));

  always_comb begin
    order_err_d = order_err_q;
    if (beat && (idx_q != '0) && (out_data < prev_elem)) order_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) order_err_q <= 1'b0;
    else       order_err_q <= order_err_d;
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_out_serializer.sv
// tb/tb_sort_out_serializer.sv - directed self-checking bench for sort_out_serializer
module tb_sort_out_serializer;

  logic        clk;
  logic        reset;
  logic        frame_valid;
  logic [31:0] in_frame;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [7:0]  drop_cnt;
  logic        order_err;

  int total = 0;
  int bad   = 0;

`ifdef SORT_ORDER_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  sort_out_serializer #(
    .n          (4),
    .k          (8),
    .FIFO_DEPTH (4),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .in_frame    (in_frame),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .drop_cnt    (drop_cnt),
    .order_err   (order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_beat(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_last"},  32'(out_last),  32'(l));
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic l);
    check_beat(tag, d, l);
    step();
  endtask

  function automatic logic [31:0] make_frame(input logic [7:0] base);
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  initial begin
    reset       = 1'b1;
    frame_valid = 1'b0;
    in_frame    = '0;
    out_ready   = 1'b0;
    step();
    step();

    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_drop",  32'(drop_cnt),  32'd0);
    check("rst_oerr",  32'(order_err), 32'd0);
    reset = 1'b0;
    step();

    // single frame, latency t+2
    out_ready   = 1'b1;
    frame_valid = 1'b1;
    in_frame    = 32'h40302010;
    step();
    frame_valid = 1'b0;
    check("t1_lat1", 32'(out_valid), 32'd0);
    step();
    expect_beat("t1_b0", 8'h10, 1'b0);
    expect_beat("t1_b1", 8'h20, 1'b0);
    expect_beat("t1_b2", 8'h30, 1'b0);
    expect_beat("t1_b3", 8'h40, 1'b1);
    check("t1_idle", 32'(out_valid), 32'd0);

    // backpressure on beat 2 for three cycles
    frame_valid = 1'b1;
    in_frame    = 32'h40302010;
    step();
    frame_valid = 1'b0;
    step();
    expect_beat("t2_b0", 8'h10, 1'b0);
    out_ready = 1'b0;
    check_beat("t2_hold0", 8'h20, 1'b0);
    step();
    check_beat("t2_hold1", 8'h20, 1'b0);
    step();
    check_beat("t2_hold2", 8'h20, 1'b0);
    step();
    out_ready = 1'b1;
    expect_beat("t2_b1", 8'h20, 1'b0);
    expect_beat("t2_b2", 8'h30, 1'b0);
    expect_beat("t2_b3", 8'h40, 1'b1);
    check("t2_idle", 32'(out_valid), 32'd0);

    // back-to-back frames on consecutive cycles
    frame_valid = 1'b1;
    in_frame    = 32'h04030201;
    step();
    in_frame = 32'h08070605;
    check("t3_lat1", 32'(out_valid), 32'd0);
    step();
    frame_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      expect_beat($sformatf("t3_b%0d", j), 8'(j + 1), (j == 3) || (j == 7));
    end
    check("t3_idle", 32'(out_valid), 32'd0);

    // overflow: one frame parked in the output stage, then 10 frames on a stalled sink
    out_ready   = 1'b0;
    frame_valid = 1'b1;
    in_frame    = make_frame(8'hF0);
    step();
    frame_valid = 1'b0;
    step();
    check_beat("t4_park", 8'hF0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      frame_valid = 1'b1;
      in_frame    = make_frame(8'(16 * i));
      step();
    end
    frame_valid = 1'b0;
    check("t4_drop", 32'(drop_cnt), 32'd6);
    check_beat("t4_hold", 8'hF0, 1'b0);

    // full FIFO: frame arrives on the cycle the parked frame's last beat is taken
    out_ready = 1'b1;
    expect_beat("t5_p0", 8'hF0, 1'b0);
    expect_beat("t5_p1", 8'hF1, 1'b0);
    expect_beat("t5_p2", 8'hF2, 1'b0);
    frame_valid = 1'b1;
    in_frame    = make_frame(8'hA0);
    expect_beat("t5_p3", 8'hF3, 1'b1);
    frame_valid = 1'b0;
    check("t5_drop", 32'(drop_cnt), 32'd6);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        expect_beat($sformatf("t4_f%0d_b%0d", i, j), 8'(16 * i + j), j == 3);
      end
    end
    for (int j = 0; j < 4; j++) begin
      expect_beat($sformatf("t5_q_b%0d", j), 8'(8'hA0 + j), j == 3);
    end
    check("t5_idle", 32'(out_valid), 32'd0);
    check("t5_oerr", 32'(order_err), 32'd0);

    // asynchronous reset after beat 2, with a second frame buffered
    frame_valid = 1'b1;
    in_frame    = make_frame(8'h50);
    step();
    in_frame = make_frame(8'h60);
    step();
    frame_valid = 1'b0;
    expect_beat("t6_b0", 8'h50, 1'b0);
    expect_beat("t6_b1", 8'h51, 1'b0);
    check_beat("t6_pre", 8'h52, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_drop",  32'(drop_cnt),  32'd0);
    check("t6_rst_last",  32'(out_last),  32'd0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("t6_stale%0d", c), 32'(out_valid), 32'd0);
    end

    // out-of-order frame {10,20,05,30}; flag only exists with the checker built
    frame_valid = 1'b1;
    in_frame    = 32'h30052010;
    step();
    frame_valid = 1'b0;
    step();
    expect_beat("t7_b0", 8'h10, 1'b0);
    expect_beat("t7_b1", 8'h20, 1'b0);
    check_beat("t7_b2", 8'h05, 1'b0);
    check("t7_oerr_pre", 32'(order_err), 32'd0);
    step();
    check_beat("t7_b3", 8'h30, 1'b1);
    check("t7_oerr_set", 32'(order_err), 32'(CHK_EN));
    step();
    check("t7_idle", 32'(out_valid), 32'd0);
    frame_valid = 1'b1;
    in_frame    = make_frame(8'h70);
    step();
    frame_valid = 1'b0;
    step();
    for (int j = 0; j < 4; j++) begin
      expect_beat($sformatf("t7_ok_b%0d", j), 8'(8'h70 + j), j == 3);
    end
    check("t7_oerr_sticky", 32'(order_err), 32'(CHK_EN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
